// File: rtl/i2c_cfg_seq_pkg.sv
// -----------------------------------------------------------------------------
// utils
//   Shared definitions for the I2C configuration sequencer: the ceiling-log2
//   helper used to size address and counter fields, the ROM opcode values and
//   the sequencer state encoding.
// -----------------------------------------------------------------------------
package utils;

    // Bits needed to represent values 0..v-1 (never less than 1).
    function automatic int cl2(input int unsigned v);
        int          r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam logic [7:0] OP_WRITE = 8'h00;
    localparam logic [7:0] OP_DELAY = 8'h01;
    localparam logic [7:0] OP_END   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_ROM  = 3'd2,
        ST_DECODE    = 3'd3,
        ST_ISSUE     = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_DELAY     = 3'd6,
        ST_FINISH    = 3'd7
    } state_t;

endpackage

// File: rtl/i2c_cfg_seq.sv
// -----------------------------------------------------------------------------
// i2c_cfg_seq
//   Walks a configuration ROM and turns each entry into an I2C register write
//   command, a millisecond-style delay, a no-op, or the end of the sequence.
//   A NACK on any write aborts the remaining entries and raises a sticky err.
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : level request, sampled only while idle
//   rom_addr  : ROM read address (data returns one clock later)
//   rom_data  : ROM read data {dev[6:0], rsvd, reg[7:0], data[7:0], op[7:0]}
//   m_valid   : command valid to the I2C master (held until m_ready)
//   m_dev     : 7-bit device address of the command
//   m_reg     : register address of the command
//   m_data    : data byte of the command
//   m_ready   : master accepts the command
//   m_done    : master transaction-complete pulse
//   m_nack    : master saw a NACK, qualified by m_done
//   busy      : sequence in progress
//   done      : one-clock pulse when the sequence finishes
//   err       : sticky NACK flag, cleared by the next start
// -----------------------------------------------------------------------------
module i2c_cfg_seq
    import utils::*;
#(
    parameter int LINES      = 16,
    parameter int DW         = 32,
    parameter int DELAY_TICK = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [cl2(LINES)-1:0]  rom_addr,
    input  logic [DW-1:0]          rom_data,
    output logic                   m_valid,
    output logic [6:0]             m_dev,
    output logic [7:0]             m_reg,
    output logic [7:0]             m_data,
    input  logic                   m_ready,
    input  logic                   m_done,
    input  logic                   m_nack,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int AW = cl2(LINES);
    localparam int CW = cl2(255 * DELAY_TICK + 1);

    state_t          r_state;
    logic [AW-1:0]   r_index;
    logic [CW-1:0]   r_cnt;

    logic [6:0]      w_dev;
    logic [7:0]      w_reg;
    logic [7:0]      w_data;
    logic [7:0]      w_op;
    logic            w_last;
    state_t          w_adv_state;
    logic [AW-1:0]   w_adv_index;
    logic [CW-1:0]   w_delay_load;

    assign w_dev  = rom_data[31:25];
    assign w_reg  = rom_data[23:16];
    assign w_data = rom_data[15:8];
    assign w_op   = rom_data[7:0];

    // Moving past an entry: the last ROM line ends the sequence rather than
    // wrapping back to entry 0.
    assign w_last      = (r_index == AW'(LINES - 1));
    assign w_adv_state = w_last ? ST_FINISH : ST_FETCH;
    assign w_adv_index = w_last ? r_index : r_index + 1'b1;

    // The DELAY state lasts data*DELAY_TICK clocks; the counter runs down to
    // zero inclusive, hence the minus one.
    assign w_delay_load = CW'(({24'd0, w_data} * DELAY_TICK) - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_index  <= '0;
            r_cnt    <= '0;
            rom_addr <= '0;
            m_valid  <= 1'b0;
            m_dev    <= '0;
            m_reg    <= '0;
            m_data   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        err     <= 1'b0;
                        r_index <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    rom_addr <= r_index;
                    r_state  <= ST_WAIT_ROM;
                end
                ST_WAIT_ROM: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    case (w_op)
                        OP_WRITE: begin
                            m_dev   <= w_dev;
                            m_reg   <= w_reg;
                            m_data  <= w_data;
                            m_valid <= 1'b1;
                            r_state <= ST_ISSUE;
                        end
                        OP_DELAY: begin
                            if (w_data != 8'd0) begin
                                r_cnt   <= w_delay_load;
                                r_state <= ST_DELAY;
                            end else begin
                                r_index <= w_adv_index;
                                r_state <= w_adv_state;
                            end
                        end
                        OP_END: begin
                            r_state <= ST_FINISH;
                        end
                        default: begin
                            r_index <= w_adv_index;
                            r_state <= w_adv_state;
                        end
                    endcase
                end
                ST_ISSUE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (m_done) begin
                        if (m_nack) begin
                            err     <= 1'b1;
                            r_state <= ST_FINISH;
                        end else begin
                            r_index <= w_adv_index;
                            r_state <= w_adv_state;
                        end
                    end
                end
                ST_DELAY: begin
                    if (r_cnt == '0) begin
                        r_index <= w_adv_index;
                        r_state <= w_adv_state;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_cfg_seq.md
I2C_CFG_SEQ -- requirements
Module: i2c_cfg_seq

Interface
REQ-001 SHALL have parameter LINES, default 16, giving the number of config ROM entries.
REQ-002 SHALL have parameter DW, default 32, giving the ROM word width; it is fixed at 32.
REQ-003 SHALL have parameter DELAY_TICK, default 100000, giving clocks per delay unit (1 ms at 100 MHz).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: level; sampled only in IDLE.
REQ-007 SHALL have port rom_addr, output, cl2(LINES) bits: ROM read address.
REQ-008 SHALL have port rom_data, input, DW bits: ROM read data, valid one clock after rom_addr.
REQ-009 SHALL have the following I2C master command outputs: m_valid (1), m_dev (7), m_reg (8), m_data (8).
REQ-010 SHALL have port m_ready, input, 1 bit: master accepts a command.
REQ-011 SHALL have inputs m_done (1 bit, transaction-complete pulse) and m_nack (1 bit, qualified by m_done).
REQ-012 SHALL have outputs busy (1, level), done (1, one-clock pulse) and err (1, sticky).

Function
REQ-013 SHALL decode each ROM word as follows:
- [31:25] is the device address.
- [24] is reserved.
- [23:16] is the register.
- [15:8] is the data.
- [7:0] is the opcode: 0x00 WRITE, 0x01 DELAY, 0xFF END; any other value is treated as a NOP.
REQ-014 SHALL implement states IDLE, FETCH, WAIT_ROM, DECODE, ISSUE, WAIT_DONE, DELAY, FINISH.
REQ-015 SHALL, in IDLE with start=1, clear err, set index=0, assert busy and go to FETCH.
REQ-016 SHALL drive rom_addr=index in FETCH, go to WAIT_ROM, then go to DECODE, giving rom_data 1-cycle latency.
REQ-017 SHALL register rom_data in DECODE and branch as follows:
- WRITE -> ISSUE.
- DELAY with data!=0 -> DELAY.
- DELAY with data==0, or NOP -> advance.
- END -> FINISH.
REQ-018 SHALL, in ISSUE, hold m_valid=1 with m_dev/m_reg/m_data stable until the cycle m_valid&m_ready, then go to WAIT_DONE.
REQ-019 SHALL, in WAIT_DONE on m_done with m_nack=0, advance.
REQ-020 SHALL, in WAIT_DONE on m_done with m_nack=1, set err=1 and go to FINISH, aborting remaining entries.
REQ-021 SHALL, in DELAY, count data*DELAY_TICK clocks (counter width cl2(255*DELAY_TICK+1)), then advance.
REQ-022 SHALL advance as follows:
- If index==LINES-1, go to FINISH; no wrap to 0.
- Otherwise index+1 -> FETCH.
REQ-023 SHALL, in FINISH, pulse done for exactly one clock, deassert busy and return to IDLE.
REQ-024 SHALL ignore start while busy=1; start held high after FINISH restarts the sequence the next cycle.
REQ-025 SHALL ignore m_done outside WAIT_DONE.
REQ-026 SHALL assert m_valid only in ISSUE.

Reset
REQ-027 SHALL, on rst_n=0, immediately enter IDLE; no drain of an in-flight I2C command.
REQ-028 SHALL reset all outputs and internal registers to zero:
- Outputs: busy, done, err, m_valid, m_dev, m_reg, m_data, rom_addr.
- Internal: index, delay counter.
REQ-029 SHALL require no ROM contents to be valid during reset.

Structure
REQ-030 SHALL place the opcode constants (OP_WRITE, OP_DELAY, OP_END) and the state enum typedef in package utils, alongside cl2.
REQ-031 SHALL instantiate no sub-modules; the config ROM and I2C master are instantiated by the parent alongside this block.

Verification
REQ-032 SHALL cover a basic write sequence:
- Stimulus: ROM [0x3A2C5A00, 0x3A2D1100, 0x000000FF], m_ready=1, m_done 5 clks after accept, m_nack=0.
- Response: two commands (dev 0x1D reg 0x2C data 0x5A, then dev 0x1D reg 0x2D data 0x11), then done pulse, err=0.
REQ-033 SHALL cover the delay opcode:
- Stimulus: entry 0x00000301 with DELAY_TICK=4.
- Response: busy stays high and no m_valid for 12 clocks, then fetch of the next entry.
REQ-034 SHALL cover backpressure:
- Stimulus: m_ready low for 7 cycles.
- Response: m_valid and the fields stay stable for all 7 cycles; exactly one handshake occurs.
REQ-035 SHALL cover NACK:
- Stimulus: m_nack=1 on the second write's m_done.
- Response: err=1, done pulse, no third command; err clears on the next start.
REQ-036 SHALL cover the no-END case:
- Stimulus: all 16 entries are WRITE.
- Response: 16 commands with rom_addr 0..15, then FINISH; no wrap to 0.
REQ-037 SHALL cover reset mid-operation:
- Stimulus: rst_n low during WAIT_DONE.
- Response: all outputs 0 the same cycle, IDLE on release, and no action without start.
